jpeg_hex_stream_ctrl: RTL and testbench

Front-end sequencer between the ASCII-hex image source and the JPEG decoder core. It consumes a character stream in which each image byte is two hex digits and whitespace/newlines may appear anywhere. It assembles bytes, tracks JPEG marker/segment structure, and routes header-segment bytes and de-stuffed entropy-coded bytes to separate valid/ready outputs.

---
 rtl/jpeg_pkg.sv | 45 ++++
 rtl/ascii_hex_decode.sv | 28 ++
 rtl/jpeg_hex_stream_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_jpeg_hex_stream_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the ASCII-hex JPEG front-end sequencer.
// Holds the FSM state encoding, JPEG marker codes and error codes.
package jpeg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOI0,
    ST_SOI1,
    ST_MK0,
    ST_MK1,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_BODY,
    ST_ECS,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] MK_PREFIX = 8'hFF;
  localparam logic [7:0] MK_SOI    = 8'hD8;
  localparam logic [7:0] MK_EOI    = 8'hD9;
  localparam logic [7:0] MK_SOS    = 8'hDA;
  localparam logic [7:0] MK_TEM    = 8'h01;
  localparam logic [7:0] MK_STUFF  = 8'h00;
  localparam logic [7:0] MK_RST0   = 8'hD0;
  localparam logic [7:0] MK_RST1   = 8'hD1;
  localparam logic [7:0] MK_RST2   = 8'hD2;
  localparam logic [7:0] MK_RST3   = 8'hD3;
  localparam logic [7:0] MK_RST4   = 8'hD4;
  localparam logic [7:0] MK_RST5   = 8'hD5;
  localparam logic [7:0] MK_RST6   = 8'hD6;
  localparam logic [7:0] MK_RST7   = 8'hD7;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_BAD_CHAR   = 3'd1;
  localparam logic [2:0] ERR_NO_SOI     = 3'd2;
  localparam logic [2:0] ERR_BAD_LEN    = 3'd3;
  localparam logic [2:0] ERR_BAD_MARKER = 3'd4;

  // RST0..RST7 share the 1101_0xxx pattern.
  function automatic logic is_rst(input logic [7:0] b);
    return b[7:3] == MK_RST0[7:3];
  endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier for one ASCII character: hex digit, whitespace,
// and the 4-bit value when it is a hex digit.
module ascii_hex_decode (
  input  logic [7:0] ch_i,
  output logic       is_hex_o,
  output logic       is_ws_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_hex_o = 1'b0;
    is_ws_o  = 1'b0;
    nibble_o = 4'h0;
    if (ch_i >= "0" && ch_i <= "9") begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i - "0");
    end else if (ch_i >= "a" && ch_i <= "f") begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i - "a" + 8'd10);
    end else if (ch_i >= "A" && ch_i <= "F") begin
      is_hex_o = 1'b1;
      nibble_o = 4'(ch_i - "A" + 8'd10);
    end else if (ch_i == 8'h20 || ch_i == 8'h09 || ch_i == 8'h0D || ch_i == 8'h0A) begin
      is_ws_o = 1'b1;
    end
  end

endmodule

// File: rtl/jpeg_hex_stream_ctrl.sv
// Assembles hex-digit pairs into bytes, walks JPEG marker/segment structure
// and routes header bodies and de-stuffed scan data to separate streams.
module jpeg_hex_stream_ctrl
  import jpeg_pkg::*;
#(
  parameter int SEG_LEN_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic       hdr_valid,
  output logic [7:0] hdr_data,
  output logic [7:0] hdr_marker,
  input  logic       hdr_ready,
  output logic       ecs_valid,
  output logic [7:0] ecs_data,
  input  logic       ecs_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_code
);

  state_t                 state_q;
  logic                   nib_hi_q;
  logic [3:0]             hi_nib_q;
  logic [7:0]             len_hi_q;
  logic [SEG_LEN_W-1:0]   len_q;
  logic [7:0]             seg_marker_q;
  logic                   ff_pend_q;
  logic                   hdr_valid_q, ecs_valid_q;
  logic [7:0]             hdr_data_q, hdr_marker_q, ecs_data_q;
  logic                   busy_q, done_q, err_q;
  logic [2:0]             err_code_q;

  logic                   dec_is_hex, dec_is_ws;
  logic [3:0]             dec_nibble;
  logic                   accept_d, bad_char_d, byte_vld_d;
  logic [7:0]             byte_d;
  logic [15:0]            seg_len_d;

  ascii_hex_decode u_dec (
    .ch_i     (ch_data),
    .is_hex_o (dec_is_hex),
    .is_ws_o  (dec_is_ws),
    .nibble_o (dec_nibble)
  );

  // A held byte draining this cycle frees its slot, so no bubble is needed.
  assign ch_ready = busy_q && ((!hdr_valid_q && !ecs_valid_q) ||
                               (hdr_valid_q && hdr_ready) ||
                               (ecs_valid_q && ecs_ready));

  always_comb begin
    accept_d   = ch_valid && ch_ready;
    bad_char_d = accept_d && !dec_is_hex && !dec_is_ws;
    byte_vld_d = accept_d && dec_is_hex && !nib_hi_q;
    byte_d     = {hi_nib_q, dec_nibble};
    seg_len_d  = {len_hi_q, byte_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      nib_hi_q     <= 1'b1;
      hi_nib_q     <= 4'h0;
      len_hi_q     <= 8'h00;
      len_q        <= '0;
      seg_marker_q <= 8'h00;
      ff_pend_q    <= 1'b0;
      hdr_valid_q  <= 1'b0;
      hdr_data_q   <= 8'h00;
      hdr_marker_q <= 8'h00;
      ecs_valid_q  <= 1'b0;
      ecs_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      if (hdr_valid_q && hdr_ready) hdr_valid_q <= 1'b0;
      if (ecs_valid_q && ecs_ready) ecs_valid_q <= 1'b0;

      if (start && !busy_q) begin
        state_q    <= ST_SOI0;
        busy_q     <= 1'b1;
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
        nib_hi_q   <= 1'b1;
        ff_pend_q  <= 1'b0;
        len_q      <= '0;
      end else if (bad_char_d) begin
        state_q    <= ST_ERR;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
        err_code_q <= ERR_BAD_CHAR;
      end else if (accept_d && dec_is_hex && nib_hi_q) begin
        hi_nib_q <= dec_nibble;
        nib_hi_q <= 1'b0;
      end else if (byte_vld_d) begin
        nib_hi_q <= 1'b1;
        unique case (state_q)
          ST_SOI0, ST_SOI1: begin
            if (state_q == ST_SOI0 && byte_d == MK_PREFIX) begin
              state_q <= ST_SOI1;
            end else if (state_q == ST_SOI1 && byte_d == MK_SOI) begin
              state_q <= ST_MK0;
            end else begin
              state_q    <= ST_ERR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_NO_SOI;
            end
          end
          ST_MK0: begin
            if (byte_d == MK_PREFIX) begin
              state_q <= ST_MK1;
            end else begin
              state_q    <= ST_ERR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_MARKER;
            end
          end
          ST_MK1: begin
            if (byte_d == MK_PREFIX) begin
              state_q <= ST_MK1;
            end else if (byte_d == MK_EOI) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (byte_d == MK_TEM || is_rst(byte_d)) begin
              state_q    <= ST_ERR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_MARKER;
            end else begin
              seg_marker_q <= byte_d;
              state_q      <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            len_hi_q <= byte_d;
            state_q  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            // The length field counts its own two bytes.
            if (seg_len_d < 16'd2) begin
              state_q    <= ST_ERR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_BAD_LEN;
            end else if (seg_len_d == 16'd2) begin
              state_q <= (seg_marker_q == MK_SOS) ? ST_ECS : ST_MK0;
            end else begin
              len_q   <= SEG_LEN_W'(seg_len_d - 16'd2);
              state_q <= ST_BODY;
            end
          end
          ST_BODY: begin
            hdr_valid_q  <= 1'b1;
            hdr_data_q   <= byte_d;
            hdr_marker_q <= seg_marker_q;
            len_q        <= len_q - SEG_LEN_W'(1);
            if (len_q == SEG_LEN_W'(1))
              state_q <= (seg_marker_q == MK_SOS) ? ST_ECS : ST_MK0;
          end
          ST_ECS: begin
            if (!ff_pend_q) begin
              if (byte_d == MK_PREFIX) begin
                ff_pend_q <= 1'b1;
              end else begin
                ecs_valid_q <= 1'b1;
                ecs_data_q  <= byte_d;
              end
            end else if (byte_d == MK_STUFF) begin
              ff_pend_q   <= 1'b0;
              ecs_valid_q <= 1'b1;
              ecs_data_q  <= MK_PREFIX;
            end else if (is_rst(byte_d)) begin
              ff_pend_q <= 1'b0;
            end else if (byte_d == MK_EOI) begin
              ff_pend_q <= 1'b0;
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else if (byte_d != MK_PREFIX) begin
              ff_pend_q    <= 1'b0;
              seg_marker_q <= byte_d;
              state_q      <= ST_LEN_HI;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hdr_valid  = hdr_valid_q;
  assign hdr_data   = hdr_data_q;
  assign hdr_marker = hdr_marker_q;
  assign ecs_valid  = ecs_valid_q;
  assign ecs_data   = ecs_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_jpeg_hex_stream_ctrl.sv
// Directed bench for jpeg_hex_stream_ctrl: short hex streams with
// hand-computed header/scan bytes, stalls, errors and mid-stream reset.
module tb_jpeg_hex_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = 8'h00;
  logic       ch_ready;
  logic       hdr_valid;
  logic [7:0] hdr_data;
  logic [7:0] hdr_marker;
  logic       hdr_ready = 1'b1;
  logic       ecs_valid;
  logic [7:0] ecs_data;
  logic       ecs_ready = 1'b1;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] err_code;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int excl_viol = 0;
  logic [15:0] hq[$];
  logic [7:0]  eq[$];

  jpeg_hex_stream_ctrl #(.SEG_LEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .hdr_valid  (hdr_valid),
    .hdr_data   (hdr_data),
    .hdr_marker (hdr_marker),
    .hdr_ready  (hdr_ready),
    .ecs_valid  (ecs_valid),
    .ecs_data   (ecs_data),
    .ecs_ready  (ecs_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Consumers and pulse counters; ready inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid && hdr_ready) hq.push_back({hdr_marker, hdr_data});
      if (ecs_valid && ecs_ready) eq.push_back(ecs_data);
      if (done) done_cnt++;
      if (hdr_valid && ecs_valid) excl_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    bit ok = 1'b0;
    ch_valid = 1'b1;
    ch_data  = c;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (ch_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      check("ch_timeout", 32'(c), 32'hFFFF);
      @(posedge clk);
      #1;
    end
    ch_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  int hb, eb, db;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ch_ready", 32'(ch_ready), 32'd0);
    check("rst_outs", 32'({hdr_valid, ecs_valid, busy, done, err, err_code}), 32'd0);
    check("rst_data", 32'({hdr_data, hdr_marker, ecs_data}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Header segment with whitespace, including between nibbles of one byte
    hb = hq.size(); db = done_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send_str("FFD8\nFFDB\n0004\nA 1");
    check("t1_lat_valid", 32'(hdr_valid), 32'd1);
    check("t1_lat_data", 32'({hdr_marker, hdr_data}), 32'hDBA1);
    send_str("B2\nFFD9");
    settle();
    check("t1_hdr_cnt", 32'(hq.size() - hb), 32'd2);
    check("t1_hdr0", 32'(hq[hb]), 32'hDBA1);
    check("t1_hdr1", 32'(hq[hb+1]), 32'hDBB2);
    check("t1_done", 32'(done_cnt - db), 32'd1);
    check("t1_err_busy", 32'({err, busy}), 32'd0);

    // Scan data with byte stuffing, restart marker and EOI
    eb = eq.size(); db = done_cnt;
    pulse_start();
    send_str("FFD8 FFDA 0002 12 FF");
    @(posedge clk);
    #1;
    check("t2_ff_held", 32'(ecs_valid), 32'd0);
    send_str("00");
    check("t2_ff_emit", 32'({ecs_valid, ecs_data}), 32'h1FF);
    send_str(" 34 FFD3 56 FFD9");
    settle();
    check("t2_ecs_cnt", 32'(eq.size() - eb), 32'd4);
    check("t2_ecs0", 32'(eq[eb]), 32'h12);
    check("t2_ecs1", 32'(eq[eb+1]), 32'hFF);
    check("t2_ecs2", 32'(eq[eb+2]), 32'h34);
    check("t2_ecs3", 32'(eq[eb+3]), 32'h56);
    check("t2_done", 32'(done_cnt - db), 32'd1);

    // Header stall: fill byte before marker, consumer not ready for 10 cycles
    hb = hq.size(); db = done_cnt;
    hdr_ready = 1'b0;
    pulse_start();
    send_str("FFD8FFFFE00005C3");
    ch_valid = 1'b1;
    ch_data  = "7";
    repeat (10) begin
      @(posedge clk);
      #1;
      check("t3_stall_rdy", 32'(ch_ready), 32'd0);
      check("t3_stall_data", 32'({hdr_valid, hdr_marker, hdr_data}), 32'h1E0C3);
    end
    ch_valid  = 1'b0;
    hdr_ready = 1'b1;
    send_str("7D4EFFD9");
    settle();
    check("t3_hdr_cnt", 32'(hq.size() - hb), 32'd3);
    check("t3_hdr0", 32'(hq[hb]), 32'hE0C3);
    check("t3_hdr1", 32'(hq[hb+1]), 32'hE07D);
    check("t3_hdr2", 32'(hq[hb+2]), 32'hE04E);
    check("t3_done", 32'(done_cnt - db), 32'd1);

    // Missing SOI, then start clears the error
    pulse_start();
    send_str("FFC0");
    check("t4_no_soi", 32'({err, err_code, busy}), 32'({1'b1, 3'd2, 1'b0}));
    pulse_start();
    check("t4_clear", 32'({err, err_code, busy}), 32'({1'b0, 3'd0, 1'b1}));

    // Bad character between nibbles
    send_str("FFDG");
    check("t5_bad_char", 32'({err, err_code, busy}), 32'({1'b1, 3'd1, 1'b0}));

    // Segment length below 2
    pulse_start();
    send_str("FFD8FFC40001");
    check("t6_bad_len", 32'({err, err_code, busy}), 32'({1'b1, 3'd3, 1'b0}));

    // Reset mid-body with a dangling high nibble, then a fresh image
    pulse_start();
    send_str("FFD8FFFE0006ABC");
    rst_n = 1'b0;
    #1;
    check("t7_rst_outs", 32'({ch_ready, hdr_valid, ecs_valid, busy, done, err}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hb = hq.size(); db = done_cnt;
    pulse_start();
    send_str("FFD8\nFFDB\n0004\nA1B2\nFFD9");
    settle();
    check("t7_hdr_cnt", 32'(hq.size() - hb), 32'd2);
    check("t7_hdr0", 32'(hq[hb]), 32'hDBA1);
    check("t7_hdr1", 32'(hq[hb+1]), 32'hDBB2);
    check("t7_done_err", 32'({done_cnt - db, 3'(err_code), 1'(err)}), 32'({32'd1, 3'd0, 1'b0}));

    check("excl_valid", 32'(excl_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
